hazard_fwd_ctrl: RTL and testbench

Hazard and forwarding controller for the 5-stage pipeline; consumes the destination/write-enable fields published by the EX/MEM and MEM/WB pipeline registers. Drives ALU operand forwarding selects, stalls the IF/ID stages, and inserts EX bubbles. Sequences multi-cycle load-use and compare-branch stalls, and the taken-branch flush, with a small registered FSM.

---
 rtl/hazard_fwd_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - operand forwarding, load-use/CBZ stall sequencing and branch flush.
// Optional HAZARD_STATS_EN adds a saturating stall-cycle counter port (stallCount).
module hazard_fwd_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rn_id,
    input  logic [4:0] Rm_id,
    input  logic       useRn_id,
    input  logic       useRm_id,
    input  logic       cbz_id,
    input  logic [4:0] Rd_ex,
    input  logic [4:0] Rd_mem,
    input  logic [4:0] Rd_wr,
    input  logic       RegWrite_ex,
    input  logic       RegWrite_mem,
    input  logic       RegWrite_wr,
    input  logic       MemRead_ex,
    input  logic       MemRead_mem,
    input  logic       brTaken_id,
    output logic [1:0] fwdA,
    output logic [1:0] fwdB,
    output logic       stall_pc,
    output logic       stall_ifid,
    output logic       bubble_idex,
    output logic       flush_ifid
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stallCount
`endif
);

    typedef enum logic [1:0] {RUN, STALL1, STALL2} state_t;

    state_t     state;
    state_t     state_next;
    logic [4:0] rn_ex;
    logic [4:0] rm_ex;
    logic       load_use;
    logic       cbz_load;
    logic       cbz_alu;
    logic       stall;

    // X31 is hard-wired zero, so it never carries a dependency
    function automatic logic match(input logic we, input logic [4:0] rd, input logic [4:0] r);
        return we && (rd == r) && (r != 5'd31);
    endfunction

    always_comb begin
        load_use = MemRead_ex && ((useRn_id && match(RegWrite_ex, Rd_ex, Rn_id)) ||
                                  (useRm_id && match(RegWrite_ex, Rd_ex, Rm_id)));
        cbz_load = cbz_id && MemRead_ex && match(RegWrite_ex, Rd_ex, Rm_id);
        cbz_alu  = cbz_id && ((match(RegWrite_ex, Rd_ex, Rm_id) && !MemRead_ex) ||
                              (MemRead_mem && match(RegWrite_mem, Rd_mem, Rm_id)));
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            RUN: begin
                if (cbz_load) begin
                    state_next = STALL2;
                    stall      = 1'b1;
                end else if (load_use || cbz_alu) begin
                    state_next = STALL1;
                    stall      = 1'b1;
                end
            end
            STALL2: begin
                state_next = STALL1;
                stall      = 1'b1;
            end
            STALL1: begin
                state_next = RUN;
                stall      = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_comb begin
        fwdA = 2'b00;
        fwdB = 2'b00;
        if (match(RegWrite_mem, Rd_mem, rn_ex))
            fwdA = 2'b10;
        else if (match(RegWrite_wr, Rd_wr, rn_ex))
            fwdA = 2'b01;
        if (match(RegWrite_mem, Rd_mem, rm_ex))
            fwdB = 2'b10;
        else if (match(RegWrite_wr, Rd_wr, rm_ex))
            fwdB = 2'b01;
    end

    assign stall_pc    = stall;
    assign stall_ifid  = stall;
    assign bubble_idex = stall;
    assign flush_ifid  = brTaken_id && !stall;

    // A bubble entering ID/EX reads nothing, so its sources park on X31
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            rn_ex <= 5'd31;
            rm_ex <= 5'd31;
        end else begin
            state <= state_next;
            if (stall) begin
                rn_ex <= 5'd31;
                rm_ex <= 5'd31;
            end else begin
                rn_ex <= Rn_id;
                rm_ex <= Rm_id;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset)
            stallCount <= 16'd0;
        else if (stall && (stallCount != 16'hFFFF))
            stallCount <= stallCount + 16'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - table-driven scoreboard bench for hazard_fwd_ctrl.
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rn_id, Rm_id, Rd_ex, Rd_mem, Rd_wr;
    logic       useRn_id, useRm_id, cbz_id;
    logic       RegWrite_ex, RegWrite_mem, RegWrite_wr, MemRead_ex, MemRead_mem, brTaken_id;
    logic [1:0] fwdA, fwdB;
    logic       stall_pc, stall_ifid, bubble_idex, flush_ifid;
`ifdef HAZARD_STATS_EN
    logic [15:0] stallCount;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl dut (
        .clk(clk), .reset(reset),
        .Rn_id(Rn_id), .Rm_id(Rm_id), .useRn_id(useRn_id), .useRm_id(useRm_id), .cbz_id(cbz_id),
        .Rd_ex(Rd_ex), .Rd_mem(Rd_mem), .Rd_wr(Rd_wr),
        .RegWrite_ex(RegWrite_ex), .RegWrite_mem(RegWrite_mem), .RegWrite_wr(RegWrite_wr),
        .MemRead_ex(MemRead_ex), .MemRead_mem(MemRead_mem), .brTaken_id(brTaken_id),
        .fwdA(fwdA), .fwdB(fwdB), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
        .bubble_idex(bubble_idex), .flush_ifid(flush_ifid)
`ifdef HAZARD_STATS_EN
        , .stallCount(stallCount)
`endif
    );

    typedef struct {
        logic       rst;
        logic [4:0] rn, rm;
        logic       urn, urm, cbz;
        logic [4:0] rdex;
        logic       rwex, mrex;
        logic [4:0] rdmem;
        logic       rwmem, mrmem;
        logic [4:0] rdwr;
        logic       rwwr, br;
        logic [1:0] efa, efb;
        logic       est, efl;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(
        input logic rst, input logic [4:0] rn, input logic [4:0] rm,
        input logic urn, input logic urm, input logic cbz,
        input logic [4:0] rdex, input logic rwex, input logic mrex,
        input logic [4:0] rdmem, input logic rwmem, input logic mrmem,
        input logic [4:0] rdwr, input logic rwwr, input logic br,
        input logic [1:0] efa, input logic [1:0] efb, input logic est, input logic efl);
        vec_t v;
        v.rst = rst; v.rn = rn; v.rm = rm; v.urn = urn; v.urm = urm; v.cbz = cbz;
        v.rdex = rdex; v.rwex = rwex; v.mrex = mrex;
        v.rdmem = rdmem; v.rwmem = rwmem; v.mrmem = mrmem;
        v.rdwr = rdwr; v.rwwr = rwwr; v.br = br;
        v.efa = efa; v.efb = efb; v.est = est; v.efl = efl;
        return v;
    endfunction

    task automatic check(input string name, input int row, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; Rn_id = v.rn; Rm_id = v.rm; useRn_id = v.urn; useRm_id = v.urm;
        cbz_id = v.cbz; Rd_ex = v.rdex; RegWrite_ex = v.rwex; MemRead_ex = v.mrex;
        Rd_mem = v.rdmem; RegWrite_mem = v.rwmem; MemRead_mem = v.mrmem;
        Rd_wr = v.rdwr; RegWrite_wr = v.rwwr; brTaken_id = v.br;
    endtask

    task automatic step(input vec_t v, input int row);
        vec_t e;
        drive(v);
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        check("fwdA", row, int'(fwdA), int'(e.efa));
        check("fwdB", row, int'(fwdB), int'(e.efb));
        check("stall_pc", row, int'(stall_pc), int'(e.est));
        check("stall_ifid", row, int'(stall_ifid), int'(e.est));
        check("bubble_idex", row, int'(bubble_idex), int'(e.est));
        check("flush_ifid", row, int'(flush_ifid), int'(e.efl));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t q;
        q = mk(0, 0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 2'b00,2'b00,0,0);
        drive(q);
        reset = 1'b1;
        @(posedge clk);
        #1;

        //      rst rn rm urn urm cbz rdex rwex mrex rdmem rwmem mrmem rdwr rwwr br  efa    efb  st fl
        vecs.push_back(mk(1,  0, 0, 0,0,0,  0,0,0,  0,0,0,  0,0,0, 2'b00,2'b00,0,0)); // 0 reset state
        vecs.push_back(mk(0,  2, 3, 0,0,0,  0,0,0,  0,0,0,  0,0,0, 2'b00,2'b00,0,0)); // 1 idle after reset
        vecs.push_back(mk(0,  2, 3, 0,0,0,  0,0,0,  2,1,0,  2,1,0, 2'b10,2'b00,0,0)); // 2 MEM beats WB
        vecs.push_back(mk(0, 31,31, 0,0,0,  0,0,0,  3,1,0,  2,1,0, 2'b01,2'b10,0,0)); // 3 WB on A, MEM on B
        vecs.push_back(mk(0, 31,31, 1,1,0, 31,1,1, 31,1,0, 31,1,1, 2'b00,2'b00,0,1)); // 4 X31 never matches; flush
        vecs.push_back(mk(0,  1, 5, 1,0,0,  1,1,1,  0,0,0,  0,0,1, 2'b00,2'b00,1,0)); // 5 load-use beats branch
        vecs.push_back(mk(0,  1, 5, 1,0,0,  0,0,0,  1,1,1,  0,0,0, 2'b00,2'b00,1,0)); // 6 STALL1
        vecs.push_back(mk(0,  1, 5, 1,0,0,  0,0,0,  1,1,1,  0,0,0, 2'b00,2'b00,0,0)); // 7 released
        vecs.push_back(mk(0,  0, 0, 0,0,0,  0,0,0,  0,0,0,  1,1,0, 2'b01,2'b00,0,0)); // 8 load result from WB
        vecs.push_back(mk(0,  0, 3, 0,1,1,  3,1,1,  0,0,0,  0,0,0, 2'b00,2'b00,1,0)); // 9 CBZ after load
        vecs.push_back(mk(0,  0, 3, 0,1,1,  0,0,0,  3,1,1,  0,0,0, 2'b00,2'b00,1,0)); // 10 STALL2
        vecs.push_back(mk(0,  0, 3, 0,1,1,  0,0,0,  0,0,0,  3,1,0, 2'b00,2'b00,1,0)); // 11 STALL1
        vecs.push_back(mk(0,  0, 3, 0,1,1,  0,0,0,  0,0,0,  3,1,1, 2'b00,2'b00,0,1)); // 12 released, flush
        vecs.push_back(mk(0,  0, 4, 0,1,1,  4,1,0,  0,0,0,  3,1,1, 2'b00,2'b01,1,0)); // 13 CBZ after ALU op
        vecs.push_back(mk(0,  0, 0, 0,0,0,  0,0,0,  0,0,0,  0,0,0, 2'b00,2'b00,1,0)); // 14 STALL1
        vecs.push_back(mk(0,  0, 6, 0,1,1,  0,0,0,  6,1,1,  0,0,0, 2'b00,2'b00,1,0)); // 15 CBZ, load in MEM
        vecs.push_back(mk(0,  0, 0, 0,0,0,  0,0,0,  0,0,0,  0,0,0, 2'b00,2'b00,1,0)); // 16 STALL1
        vecs.push_back(mk(0,  0, 0, 0,0,0,  0,0,0,  0,0,0,  0,0,0, 2'b00,2'b00,0,0)); // 17 RUN
        vecs.push_back(mk(0,  0, 7, 0,1,1,  7,1,1,  0,0,0,  0,0,0, 2'b00,2'b00,1,0)); // 18 CBZ after load
        vecs.push_back(mk(1,  0, 0, 0,0,0,  0,0,0,  0,0,0,  0,0,0, 2'b00,2'b00,1,0)); // 19 reset while in STALL2
        vecs.push_back(mk(0,  0, 0, 0,0,0,  0,0,0,  0,0,0,  0,0,0, 2'b00,2'b00,0,0)); // 20 no residual bubble
        vecs.push_back(mk(0,  0, 8, 0,1,0,  8,1,0,  0,0,0,  0,0,0, 2'b00,2'b00,0,0)); // 21 ALU dep, no stall
        vecs.push_back(mk(0,  0, 9, 0,1,1,  0,0,0,  9,1,0,  0,0,0, 2'b00,2'b00,0,0)); // 22 CBZ, ALU in MEM

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], i);

`ifdef HAZARD_STATS_EN
        q = mk(1, 0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 2'b00,2'b00,0,0);
        drive(q);
        @(posedge clk);
        #1;
        check("stallCount_reset", 0, int'(stallCount), 0);
        q = mk(0, 1,0, 1,0,0, 1,1,1, 0,0,0, 0,0,0, 2'b00,2'b00,1,0);
        drive(q);
        for (int i = 0; i < 3; i++) @(posedge clk);
        #1;
        check("stallCount_3", 0, int'(stallCount), 3);
        for (int i = 0; i < 69997; i++) @(posedge clk);
        #1;
        check("stallCount_sat", 0, int'(stallCount), 16'hFFFF);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("stallCount_clr", 0, int'(stallCount), 0);
        reset = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
